// File: rtl/ysyx_24110006_lsu_if.sv
// ============================================================================
//  Module   : ysyx_24110006_lsu_if
//  Purpose  : EXU/WBU request-result handshake plus AXI4-Lite data bus of the LSU
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ysyx_24110006_lsu_if;
  // Request from EXU / result to WBU
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_ren;
  logic        i_wen;
  logic [3:0]  i_wmask;
  logic [2:0]  i_read_t;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_misalign;
  // AXI4-Lite read channels
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        o_rready;
  // AXI4-Lite write channels
  logic [31:0] o_awaddr;
  logic        o_awvalid;
  logic        i_awready;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_wvalid;
  logic        i_wready;
  logic [1:0]  i_bresp;
  logic        i_bvalid;
  logic        o_bready;

  // LSU side
  modport master (
    input  i_valid, i_addr, i_wdata, i_ren, i_wen, i_wmask, i_read_t, i_ready,
    input  i_arready, i_rdata, i_rresp, i_rvalid,
    input  i_awready, i_wready, i_bresp, i_bvalid,
    output o_ready, o_valid, o_rdata, o_err, o_misalign,
    output o_araddr, o_arvalid, o_rready,
    output o_awaddr, o_awvalid, o_wdata, o_wstrb, o_wvalid, o_bready
  );

  // Environment side (pipeline neighbours and memory)
  modport slave (
    output i_valid, i_addr, i_wdata, i_ren, i_wen, i_wmask, i_read_t, i_ready,
    output i_arready, i_rdata, i_rresp, i_rvalid,
    output i_awready, i_wready, i_bresp, i_bvalid,
    input  o_ready, o_valid, o_rdata, o_err, o_misalign,
    input  o_araddr, o_arvalid, o_rready,
    input  o_awaddr, o_awvalid, o_wdata, o_wstrb, o_wvalid, o_bready
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_24110006_lsu.sv
// ============================================================================
//  Module   : ysyx_24110006_lsu
//  Purpose  : Load/store unit: one request per handshake as an AXI4-Lite master
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_24110006_lsu #(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter bit RESP_ERR_EN = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  ysyx_24110006_lsu_if.master       bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [2:0]  r_read_t;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_misalign;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_accept;
  logic        w_nonmem;
  logic        w_req_mis;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic [31:0] w_shift;
  logic [31:0] w_load_ext;

  assign w_accept = bus.i_valid && (r_state == S_IDLE);
  assign w_nonmem = !bus.i_ren && !bus.i_wen;
  assign w_aw_hs  = (r_state == S_WREQ) && !r_aw_done && bus.i_awready;
  assign w_w_hs   = (r_state == S_WREQ) && !r_w_done  && bus.i_wready;

  // Access size comes from the store mask for stores, from funct3 for loads
  always_comb begin
    w_req_mis = 1'b0;
    if (ALIGN_CHECK) begin
      if (bus.i_wen) begin
        case (bus.i_wmask)
          4'b1111: w_req_mis = |bus.i_addr[1:0];
          4'b0011: w_req_mis = bus.i_addr[0];
          default: w_req_mis = 1'b0;
        endcase
      end else if (bus.i_ren) begin
        case (bus.i_read_t)
          3'b000, 3'b100: w_req_mis = 1'b0;
          3'b001, 3'b101: w_req_mis = bus.i_addr[0];
          default:        w_req_mis = |bus.i_addr[1:0];
        endcase
      end
    end
  end

  assign w_shift = bus.i_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_read_t)
      3'b000:  w_load_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load_ext = {24'd0, w_shift[7:0]};
      3'b101:  w_load_ext = {16'd0, w_shift[15:0]};
      default: w_load_ext = w_shift;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.o_ready    = 1'b0;
    bus.o_valid    = 1'b0;
    bus.o_arvalid  = 1'b0;
    bus.o_rready   = 1'b0;
    bus.o_awvalid  = 1'b0;
    bus.o_wvalid   = 1'b0;
    bus.o_bready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) begin
          if (w_nonmem || w_req_mis) w_next = S_DONE;
          else if (bus.i_wen)        w_next = S_WREQ;
          else                       w_next = S_RADDR;
        end
      end
      S_RADDR: begin
        bus.o_arvalid = 1'b1;
        if (bus.i_arready) w_next = S_RDATA;
      end
      S_RDATA: begin
        bus.o_rready = 1'b1;
        if (bus.i_rvalid) w_next = S_DONE;
      end
      S_WREQ: begin
        // AW and W complete independently; leave once both have handshaken
        bus.o_awvalid = !r_aw_done;
        bus.o_wvalid  = !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WRESP;
      end
      S_WRESP: begin
        bus.o_bready = 1'b1;
        if (bus.i_bvalid) w_next = S_DONE;
      end
      S_DONE: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_wmask    <= 4'd0;
      r_read_t   <= 3'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= bus.i_addr;
        r_wdata    <= bus.i_wdata;
        r_wmask    <= bus.i_wmask;
        r_read_t   <= bus.i_read_t;
        r_rdata    <= w_nonmem ? bus.i_addr : 32'd0;
        r_err      <= 1'b0;
        r_misalign <= w_req_mis;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
      end
      if ((r_state == S_RDATA) && bus.i_rvalid) begin
        r_rdata <= w_load_ext;
        r_err   <= RESP_ERR_EN && (bus.i_rresp != 2'b00);
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if ((r_state == S_WRESP) && bus.i_bvalid) begin
        r_err <= RESP_ERR_EN && (bus.i_bresp != 2'b00);
      end
    end
  end

  assign bus.o_rdata    = r_rdata;
  assign bus.o_err      = r_err;
  assign bus.o_misalign = r_misalign;
  assign bus.o_araddr   = {r_addr[31:2], 2'b00};
  assign bus.o_awaddr   = {r_addr[31:2], 2'b00};
  assign bus.o_wdata    = r_wdata << {r_addr[1:0], 3'b000};
  assign bus.o_wstrb    = r_wmask << r_addr[1:0];

endmodule

`default_nettype wire
